// File: rtl/rx_dpdm_deframer.sv
`default_nettype none
// ============================================================================
// Module   : rx_dpdm_deframer
// Purpose  : USB-style D+/D- receive front end. Detects a parametrised SYNC
//            (with resync on a stray K), NRZI-decodes and bit-unstuffs the
//            data field, enforces a maximum packet length, checks the EOP
//            (SE0, SE0, J) and byte alignment, then holds done/error status
//            until the packet layer acknowledges it.
// Ports    : clk        - clock
//            rst        - asynchronous active-high reset
//            bus_in     - {dp,dm}: J=10, K=01, SE0=00, SE1=11
//            sample_en  - one bus symbol is consumed per enabled cycle
//            tx_busy    - local transmitter owns the bus; aborts a packet
//            rx_ack     - packet layer has consumed rx_done / rx_error
//            bit_out    - decoded, unstuffed data bit
//            bit_valid  - one-cycle strobe qualifying bit_out
//            got_sync   - one-cycle pulse when SYNC completes
//            end_msg    - one-cycle pulse on the first SE0 of the EOP
//            rx_done    - level: packet received cleanly
//            rx_error   - level: packet failed
//            err_code   - 1=stuff violation, 2=overflow, 3=framing
//            bit_count  - unstuffed data bits in the current packet
// Options  : RX_IDLE_TIMEOUT_EN - when defined, DONE/ERR release themselves
//            to IDLE after TIMEOUT cycles without rx_ack.
// Revision : 1.0 - initial release
// ============================================================================
module rx_dpdm_deframer #(
  parameter int SYNC_LEN  = 8,
  parameter int MAX_BITS  = 88,
  parameter int STUFF_RUN = 6,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    bus_in,
  input  logic                          sample_en,
  input  logic                          tx_busy,
  input  logic                          rx_ack,
  output logic                          bit_out,
  output logic                          bit_valid,
  output logic                          got_sync,
  output logic                          end_msg,
  output logic                          rx_done,
  output logic                          rx_error,
  output logic [1:0]                    err_code,
  output logic [$clog2(MAX_BITS+1)-1:0] bit_count
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);
  localparam int IDX_W = $clog2(SYNC_LEN);
  localparam int RUN_W = $clog2(STUFF_RUN + 1);

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_SE1 = 2'b11;

  localparam logic [1:0] ERR_STUFF = 2'd1;
  localparam logic [1:0] ERR_OVFL  = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  // Reject parameter sets the SYNC pattern / alignment check cannot support.
  if (SYNC_LEN < 4 || (SYNC_LEN % 2) != 0 || MAX_BITS < 8 ||
      STUFF_RUN < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("rx_dpdm_deframer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP1 = 3'd3,
    ST_EOP2 = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sync_idx;
  logic [RUN_W-1:0] run;
  logic [1:0]       prev_sym;

  logic       sym;
  logic [1:0] exp_sync;
  logic       last_sync;
  logic       nrzi_bit;
  logic       run_full;
  logic       count_full;
  logic       aligned;
  logic       in_packet;
  logic       holding;
  logic       release_hold;
  logic       tmo_hit;

  assign sym        = sample_en && !tx_busy;
  assign last_sync  = (sync_idx == IDX_W'(SYNC_LEN - 1));
  // K at even indices, J at odd ones, and the closing symbol is a second K.
  assign exp_sync   = (last_sync || !sync_idx[0]) ? SYM_K : SYM_J;
  // NRZI: no transition encodes a 1, a transition encodes a 0.
  assign nrzi_bit   = (bus_in == prev_sym);
  assign run_full   = (run == RUN_W'(STUFF_RUN));
  assign count_full = (bit_count == CNT_W'(MAX_BITS));
  assign aligned    = (bit_count[2:0] == 3'd0);
  assign in_packet  = (state == ST_SYNC) || (state == ST_DATA) ||
                      (state == ST_EOP1) || (state == ST_EOP2);
  assign holding    = (state == ST_DONE) || (state == ST_ERR);
  assign release_hold = rx_ack || tmo_hit;

`ifdef RX_IDLE_TIMEOUT_EN
  // Counts cycles spent in DONE/ERR; zero on the first held cycle, so the
  // release edge comes after exactly TIMEOUT held cycles.
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
    end else if (holding) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  assign tmo_hit = holding && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sync_idx  <= '0;
      run       <= '0;
      prev_sym  <= SYM_K;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      got_sync  <= 1'b0;
      end_msg   <= 1'b0;
      rx_done   <= 1'b0;
      rx_error  <= 1'b0;
      err_code  <= 2'd0;
      bit_count <= '0;
    end else begin
      // Strobes are single-cycle; they are re-armed below only when earned.
      bit_valid <= 1'b0;
      got_sync  <= 1'b0;
      end_msg   <= 1'b0;

      if (tx_busy && in_packet) begin
        // Our own transmission is on the bus: drop the packet silently.
        state     <= ST_IDLE;
        run       <= '0;
        bit_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sym && (bus_in == SYM_K)) begin
              state    <= ST_SYNC;
              sync_idx <= IDX_W'(1);
            end
          end

          ST_SYNC: begin
            if (sym) begin
              if (bus_in == exp_sync) begin
                if (last_sync) begin
                  got_sync  <= 1'b1;
                  state     <= ST_DATA;
                  prev_sym  <= SYM_K;
                  bit_count <= '0;
                  run       <= '0;
                end else begin
                  sync_idx <= sync_idx + 1'b1;
                end
              end else if (bus_in == SYM_K) begin
                // A stray K may be the start of a real SYNC.
                sync_idx <= IDX_W'(1);
              end else begin
                state <= ST_IDLE;
              end
            end
          end

          ST_DATA: begin
            if (sym) begin
              if (bus_in == SYM_SE0) begin
                end_msg <= 1'b1;
                state   <= ST_EOP1;
              end else if (bus_in == SYM_SE1) begin
                state    <= ST_ERR;
                rx_error <= 1'b1;
                err_code <= ERR_FRAME;
              end else begin
                prev_sym <= bus_in;
                if (run_full) begin
                  // Mandatory stuffed 0: consumed but never delivered.
                  run <= '0;
                  if (nrzi_bit) begin
                    state    <= ST_ERR;
                    rx_error <= 1'b1;
                    err_code <= ERR_STUFF;
                  end
                end else if (count_full) begin
                  state    <= ST_ERR;
                  rx_error <= 1'b1;
                  err_code <= ERR_OVFL;
                end else begin
                  bit_out   <= nrzi_bit;
                  bit_valid <= 1'b1;
                  bit_count <= bit_count + 1'b1;
                  run       <= nrzi_bit ? run + 1'b1 : '0;
                end
              end
            end
          end

          ST_EOP1: begin
            if (sym) begin
              if (bus_in == SYM_SE0) begin
                state <= ST_EOP2;
              end else begin
                state    <= ST_ERR;
                rx_error <= 1'b1;
                err_code <= ERR_FRAME;
              end
            end
          end

          ST_EOP2: begin
            if (sym) begin
              if ((bus_in == SYM_J) && aligned) begin
                state   <= ST_DONE;
                rx_done <= 1'b1;
              end else begin
                state    <= ST_ERR;
                rx_error <= 1'b1;
                err_code <= ERR_FRAME;
              end
            end
          end

          ST_DONE, ST_ERR: begin
            // Symbols arriving while status is held are discarded.
            if (release_hold) begin
              state     <= ST_IDLE;
              rx_done   <= 1'b0;
              rx_error  <= 1'b0;
              err_code  <= 2'd0;
              bit_count <= '0;
              run       <= '0;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
